// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared types for the core memory subsystem: the encoding that
//               records which requester owns the read returning next cycle.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Owner of the read data arriving on mem_q in the cycle after a grant
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // Arbiter request/grant bit positions
    localparam int unsigned C_IDX_I = 0;
    localparam int unsigned C_IDX_D = 1;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. Grant is combinational from the
//               request vector and a priority register; the priority moves to
//               the other requester whenever a grant is issued. Reset leaves
//               requester 1 (data port) with priority and blocks all grants.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // r_prio = 1 : requester 1 wins a tie; r_prio = 0 : requester 0 wins
    logic r_prio;
    logic [1:0] w_gnt;

    // Grant selection: single requester always wins, ties go to r_prio
    always_comb begin
        w_gnt = 2'b00;
        if (!rst) begin
            case (req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_prio ? 2'b10 : 2'b01;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign gnt = w_gnt;

    // Priority register: hand priority to the port that was not just granted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b1;
        end else if (|w_gnt) begin
            r_prio <= w_gnt[0];
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port synchronous RAM between an instruction
//               fetch port and a data port. Grants are round-robin, issued in
//               the request cycle; read data returns one cycle later on the
//               port recorded in the owner register.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  clear,
    // instruction fetch port
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    // data port
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    // RAM port
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    logic [1:0] w_req;
    logic [1:0] w_gnt;
    owner_e     w_owner_nxt;
    owner_e     r_owner;

    assign w_req[C_IDX_I] = i_req;
    assign w_req[C_IDX_D] = d_req;

    rr_arb2 u_arb (
        .clk (clock),
        .rst (clear),
        .req (w_req),
        .gnt (w_gnt)
    );

    assign i_gnt = w_gnt[C_IDX_I];
    assign d_gnt = w_gnt[C_IDX_D];

    // RAM request mux: data port only when granted, fetch address otherwise
    assign mem_addr = d_gnt ? d_addr : i_addr;
    assign mem_data = d_wdata;
    assign mem_we   = d_gnt & d_we;

    // Owner of next cycle's mem_q: only granted reads produce a return
    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (i_gnt) begin
            w_owner_nxt = OWN_I;
        end else if (d_gnt && !d_we) begin
            w_owner_nxt = OWN_D;
        end
    end

    // Owner register, cleared so that no stale return survives a reset
    always_ff @(posedge clock) begin
        if (clear) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    // A read granted just before clear rose is dropped, hence the clear gate
    assign i_rvalid = (r_owner == OWN_I) && !clear;
    assign d_rvalid = (r_owner == OWN_D) && !clear;

    // Read data is broadcast; each port qualifies it with its own rvalid
    assign i_rdata = mem_q;
    assign d_rdata = mem_q;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a
//               behavioural single-port synchronous RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clock;
    logic          clear;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_we;
    logic [DW-1:0] mem_q;

    // backdoor preload port of the RAM model
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;
    logic [DW-1:0] ram [0:(1<<AW)-1];

    int n_tests;
    int n_fail;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock    (clock),
        .clear    (clear),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .mem_q    (mem_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-port synchronous RAM: address registered, q valid next cycle
    always @(posedge clock) begin
        if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_data;
        end
        mem_q <= ram[mem_addr];
    end

    // advance to just after the next rising edge
    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
        bd_addr = a;
        bd_data = v;
        bd_we   = 1'b1;
        step();
        bd_we   = 1'b0;
    endtask

    task automatic pulse_clear;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) step();
            clear = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 10'd1; d_wdata = 32'hDEAD;
            #3;
            n_tests++; if (i_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_i_gnt: got %b expected 0", i_gnt); end
            n_tests++; if (d_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_d_gnt: got %b expected 0", d_gnt); end
            n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
            n_tests++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got i=%b d=%b expected 0 0", i_rvalid, d_rvalid); end
        end
        step();
        clear = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    endtask

    task automatic test_fetch_stream;
        logic [DW-1:0] exp_q [3];
        exp_q[0] = 32'hA; exp_q[1] = 32'hB; exp_q[2] = 32'hC;
        for (int k = 0; k < 4; k++) begin
            step();
            i_req  = (k < 3);
            i_addr = AW'(4 + k);
            d_req  = 1'b0;
            #3;
            n_tests++; if (i_gnt !== (k < 3)) begin n_fail++; $display("FAIL fetch_i_gnt[%0d]: got %b expected %b", k, i_gnt, (k < 3)); end
            n_tests++; if (d_gnt !== 1'b0 || d_rvalid !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch_d_quiet[%0d]: got d_gnt=%b d_rvalid=%b mem_we=%b expected 0 0 0", k, d_gnt, d_rvalid, mem_we); end
            n_tests++; if (mem_addr !== AW'(4 + k)) begin n_fail++; $display("FAIL fetch_mem_addr[%0d]: got %0d expected %0d", k, mem_addr, 4 + k); end
            n_tests++; if (i_rvalid !== (k > 0)) begin n_fail++; $display("FAIL fetch_i_rvalid[%0d]: got %b expected %b", k, i_rvalid, (k > 0)); end
            if (k > 0) begin
                n_tests++; if (i_rdata !== exp_q[k-1]) begin n_fail++; $display("FAIL fetch_i_rdata[%0d]: got %h expected %h", k, i_rdata, exp_q[k-1]); end
            end
        end
        step();
        #3;
        n_tests++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_tail_rvalid: got i=%b d=%b expected 0 0", i_rvalid, d_rvalid); end
    endtask

    task automatic test_contention;
        logic prev_i;
        logic prev_d;
        logic exp_i;
        logic exp_d;
        prev_i = 1'b0; prev_d = 1'b0;
        pulse_clear();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            i_req = (k < 4); d_req = (k < 4); d_we = 1'b0;
            i_addr = 10'd21; d_addr = 10'd20;
            #3;
            exp_d = (k < 4) && (k % 2 == 0);
            exp_i = (k < 4) && (k % 2 == 1);
            n_tests++; if (d_gnt !== exp_d || i_gnt !== exp_i) begin n_fail++; $display("FAIL rr_grant[%0d]: got d=%b i=%b expected d=%b i=%b", k, d_gnt, i_gnt, exp_d, exp_i); end
            n_tests++; if (d_rvalid !== prev_d || i_rvalid !== prev_i) begin n_fail++; $display("FAIL rr_rvalid[%0d]: got d=%b i=%b expected d=%b i=%b", k, d_rvalid, i_rvalid, prev_d, prev_i); end
            if (prev_d) begin
                n_tests++; if (d_rdata !== 32'h200) begin n_fail++; $display("FAIL rr_d_rdata[%0d]: got %h expected 00000200", k, d_rdata); end
            end
            if (prev_i) begin
                n_tests++; if (i_rdata !== 32'h210) begin n_fail++; $display("FAIL rr_i_rdata[%0d]: got %h expected 00000210", k, i_rdata); end
            end
            prev_d = exp_d; prev_i = exp_i;
        end
    endtask

    task automatic test_write_read;
        step();
        i_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 10'd7; d_wdata = 32'h1234;
        #3;
        n_tests++; if (d_gnt !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL wr_grant: got d_gnt=%b mem_we=%b expected 1 1", d_gnt, mem_we); end
        n_tests++; if (mem_addr !== 10'd7 || mem_data !== 32'h1234) begin n_fail++; $display("FAIL wr_bus: got addr=%0d data=%h expected 7 00001234", mem_addr, mem_data); end
        step();
        d_we = 1'b0; d_wdata = 32'h0;
        #3;
        n_tests++; if (d_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd7) begin n_fail++; $display("FAIL rd_grant: got d_gnt=%b mem_we=%b addr=%0d expected 1 0 7", d_gnt, mem_we, mem_addr); end
        n_tests++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid: got %b expected 0", d_rvalid); end
        step();
        d_req = 1'b0;
        #3;
        n_tests++; if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_rvalid: got d=%b i=%b expected 1 0", d_rvalid, i_rvalid); end
        n_tests++; if (d_rdata !== 32'h1234) begin n_fail++; $display("FAIL rd_after_wr: got %h expected 00001234", d_rdata); end
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rd_mem_we: got %b expected 0", mem_we); end
        step();
        #3;
        n_tests++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_single_rvalid: got %b expected 0", d_rvalid); end
    endtask

    task automatic test_clear_abort;
        // data read granted, leaving the fetch port with priority
        step();
        i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 10'd20;
        #3;
        n_tests++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL ca_d_gnt: got %b expected 1", d_gnt); end
        step();
        d_req = 1'b0; i_req = 1'b1; i_addr = 10'd3;
        #3;
        n_tests++; if (i_gnt !== 1'b1 || d_rvalid !== 1'b1) begin n_fail++; $display("FAIL ca_i_gnt: got i_gnt=%b d_rvalid=%b expected 1 1", i_gnt, d_rvalid); end
        step();
        clear = 1'b1; i_req = 1'b0;
        #3;
        n_tests++; if (i_rvalid !== 1'b0) begin n_fail++; $display("FAIL ca_rvalid_suppressed: got %b expected 0", i_rvalid); end
        step();
        clear = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 10'd20; i_addr = 10'd3;
        #3;
        n_tests++; if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin n_fail++; $display("FAIL ca_data_first: got d=%b i=%b expected d=1 i=0", d_gnt, i_gnt); end
        n_tests++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL ca_post_rvalid: got i=%b d=%b expected 0 0", i_rvalid, d_rvalid); end
        // the grant before clear rose was a data read; data must still win
        step();
        i_req = 1'b0; d_req = 1'b1; d_addr = 10'd20;
        #3;
        step();
        clear = 1'b1; d_req = 1'b0;
        #3;
        n_tests++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL ca_d_rvalid_suppressed: got %b expected 0", d_rvalid); end
        step();
        clear = 1'b0; i_req = 1'b1; d_req = 1'b1;
        #3;
        n_tests++; if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin n_fail++; $display("FAIL ca_prio_reset: got d=%b i=%b expected d=1 i=0", d_gnt, i_gnt); end
        step();
        i_req = 1'b0; d_req = 1'b0;
        #3;
        n_tests++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h200) begin n_fail++; $display("FAIL ca_return: got rvalid=%b data=%h expected 1 00000200", d_rvalid, d_rdata); end
    endtask

    task automatic test_idle;
        for (int k = 0; k < 5; k++) begin
            step();
            i_req = 1'b0; d_req = 1'b0; d_we = 1'b1; i_addr = AW'(9 + k); d_addr = 10'd100;
            #3;
            n_tests++; if (i_gnt !== 1'b0 || d_gnt !== 1'b0) begin n_fail++; $display("FAIL idle_gnt[%0d]: got i=%b d=%b expected 0 0", k, i_gnt, d_gnt); end
            n_tests++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL idle_rvalid[%0d]: got i=%b d=%b expected 0 0", k, i_rvalid, d_rvalid); end
            n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL idle_mem_we[%0d]: got %b expected 0", k, mem_we); end
            n_tests++; if (mem_addr !== AW'(9 + k)) begin n_fail++; $display("FAIL idle_mem_addr[%0d]: got %0d expected %0d", k, mem_addr, 9 + k); end
        end
        d_we = 1'b0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        clear = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        #1;
        test_reset();
        preload(10'd4,  32'hA);
        preload(10'd5,  32'hB);
        preload(10'd6,  32'hC);
        preload(10'd20, 32'h200);
        preload(10'd21, 32'h210);
        preload(10'd3,  32'h33);
        test_fetch_stream();
        test_contention();
        test_write_read();
        test_clear_abort();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time %0t reached, expected completion earlier", $time);
        $fatal(1);
    end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, the memory word-address width.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clear, input, 1, synchronous active-high reset.
REQ-005 SHALL have port i_req, input, 1, instruction-fetch read request; held until granted.
REQ-006 SHALL have port i_addr, input, ADDR_WIDTH, fetch word address.
REQ-007 SHALL have port i_gnt, output, 1, fetch request accepted this cycle.
REQ-008 SHALL have port i_rvalid, output, 1, i_rdata valid this cycle.
REQ-009 SHALL have port i_rdata, output, DATA_WIDTH, fetch read data.
REQ-010 SHALL have port d_req, input, 1, data request; held until granted.
REQ-011 SHALL have port d_we, input, 1, data request is a write.
REQ-012 SHALL have port d_addr, input, ADDR_WIDTH, data word address.
REQ-013 SHALL have port d_wdata, input, DATA_WIDTH, write data.
REQ-014 SHALL have port d_gnt, output, 1, data request accepted this cycle.
REQ-015 SHALL have port d_rvalid, output, 1, d_rdata valid this cycle (reads only).
REQ-016 SHALL have port d_rdata, output, DATA_WIDTH, data read data.
REQ-017 SHALL have ports mem_addr (output, ADDR_WIDTH), mem_data (output, DATA_WIDTH), mem_we (output, 1), mem_q (input, DATA_WIDTH) to one single-port synchronous RAM (address registered on clock, q valid the following cycle).

Function
REQ-018 SHALL grant at most one of i_gnt/d_gnt per cycle, combinationally from the current requests and the priority register.
REQ-019 SHALL, with only one requester active, grant it every cycle (full throughput, no bubbles).
REQ-020 SHALL, with both active, grant the port not granted most recently (round-robin); after reset, data port wins first.
REQ-021 SHALL drive mem_addr/mem_data/mem_we from the granted port in the grant cycle; mem_we = d_gnt & d_we; with no grant, mem_we = 0 and mem_addr = i_addr.
REQ-022 SHALL record the owner of each granted read (NONE/I/D) in a register and assert exactly that port's rvalid one cycle after the grant, with rdata = mem_q.
REQ-023 SHALL record owner NONE for a granted write or no grant; writes produce no rvalid.
REQ-024 SHALL support a new grant in the same cycle a previous read returns (back-to-back reads, 1-cycle latency each).
REQ-025 SHALL return the just-written value for a read granted the cycle after a write to the same address.
REQ-026 SHALL drive i_rdata/d_rdata = mem_q unconditionally; data is meaningful only with its rvalid.
REQ-027 SHALL update the priority register only on a cycle with a grant.

Reset
REQ-028 SHALL, while clear = 1, force i_gnt = d_gnt = 0, mem_we = 0, owner = NONE, priority = data-first.
REQ-029 SHALL suppress any rvalid in the cycle after clear is asserted, even if a read was granted in the cycle before clear.
REQ-030 SHALL require no reset of datapath signals (mem_data, rdata).

Structure
REQ-031 SHALL take the owner encoding (OWN_NONE, OWN_I, OWN_D) from shared package riscv_pkg.
REQ-032 SHALL place two-way round-robin arbitration in sub-module rr_arb2 (req[1:0], gnt[1:0], last-grant register).

Verification
REQ-033 Only i_req for 3 cycles, i_addr 4,5,6, RAM preloaded 4->0xA, 5->0xB, 6->0xC -> i_gnt high 3 cycles; i_rvalid the next 3 cycles with 0xA, 0xB, 0xC; d_rvalid never high.
REQ-034 i_req and d_req both held 4 cycles after reset -> grants D, I, D, I; each rvalid follows its own grant by exactly one cycle.
REQ-035 d_req write addr 7 data 0x1234, then d_req read addr 7 -> mem_we high one cycle only; d_rvalid one cycle after read grant with 0x1234; no rvalid for the write.
REQ-036 i_req granted read addr 3, clear asserted next cycle -> i_rvalid stays 0; after clear drops, first contention grants data port.
REQ-037 No requests for 5 cycles -> all gnt/rvalid 0, mem_we 0 throughout.
